id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS pipeline, directly downstream of the single-cycle control decoder.
- Latches the decoded control bundle together with register-file data, immediate, register numbers, funct and PC+4 for the EX stage.
- Contains load-use hazard detection, bubble insertion, hold for downstream stalls, and flush with a pending-flush memory.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register-number width
CNT_W, 16, width of the saturating bubble counter

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_ctrl  in  12  {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Ori,Beq,Bne,Jump,ALUOp[1:0]}, MSB first
id_rs_data  in  DATA_W  rs read data
id_rt_data  in  DATA_W  rt read data
id_imm  in  DATA_W  sign/zero-extended immediate
id_pc4  in  DATA_W  PC+4 of the ID instruction
id_rs  in  REG_AW  rs number
id_rt  in  REG_AW  rt number
id_rd  in  REG_AW  rd number
id_funct  in  6  funct field
hold  in  1  downstream stall: freeze the register
flush  in  1  kill the instruction entering EX (branch/jump taken)
lu_stall  out  1  load-use stall request to PC and IF/ID (combinational)
ex_valid  out  1  EX holds a real instruction
ex_ctrl  out  12  registered control bundle
ex_rs_data, ex_rt_data, ex_imm, ex_pc4  out  DATA_W each  registered data fields
ex_rs, ex_rt, ex_rd  out  REG_AW each  registered register numbers
ex_funct  out  6  registered funct field
bubble_cnt  out  CNT_W  saturating count of bubbles inserted

Behaviour:
- Reset (asynchronous on rst_n low):
  - All outputs and internal state go to 0, including ex_valid, ex_ctrl, pend_flush and bubble_cnt.
  - Release is synchronous to clk; the first load happens at the first rising edge after release.
- Load-use detection (combinational):
  - lu_stall = ex_valid & ex_ctrl.MemRead & id_valid & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
  - Compare only ex_ctrl.MemRead and ex_rt against id_rs/id_rt.
- Priority at each rising clk, first match wins:
  1. hold: all fields keep their value. If flush is asserted, set pend_flush = 1.
  2. flush | pend_flush: load a bubble, clear pend_flush, increment bubble_cnt.
  3. lu_stall: load a bubble and increment bubble_cnt. IF/ID and PC hold externally.
  4. Otherwise: load all id_* fields and set ex_valid = id_valid.
- Bubble definition:
  - ex_valid = 0 and ex_ctrl = 0, so RegWrite, MemRead, MemWrite, Beq, Bne and Jump are all 0.
  - Data and register-number fields are loaded from id_* regardless, for waveform visibility only.
- X sanitising:
  - When id_valid = 0, ex_ctrl loads 0 rather than id_ctrl.
  - Any X bit in id_ctrl on a valid load is replaced by 0 before registering.
  - The decoder drives X for don't-care fields (SW, BEQ, BNE, J) and for unimplemented opcodes; EX must never see X.
- Latency: 1 cycle from ID to EX outputs; lu_stall has zero latency.
- bubble_cnt saturates at 2^CNT_W-1 and does not wrap.
- Simultaneous events:
  - hold with lu_stall: hold wins and lu_stall remains asserted.
  - flush with lu_stall: a single bubble is inserted and counted once.
- Reset mid-hold discards pend_flush.

Decomposition:
- Shared package mips_pkg holds:
  - The control-bundle bit positions (CTRL_REGDST..CTRL_ALUOP) and CTRL_W = 12.
  - The opcode constants R_FORMAT=0, J=2, BEQ=4, BNE=5, ORI=13, LW=35, SW=43.
  - The ALUOp encodings 00/01/10.
- One sub-module, load_use_detect, holds the combinational lu_stall equation so it can be reused by the IF/ID register.

Test Plan:
- Reset: rst_n low mid-operation with ex_valid = 1 -> all outputs 0 immediately; bubble_cnt = 0.
- Normal load: id_ctrl = R-format (RegDst=1, RegWrite=1, ALUOp=10), id_rs_data = 0x11, id_valid = 1 -> next cycle ex_ctrl matches, ex_rs_data = 0x11, ex_valid = 1.
- Load-use, dependent instruction:
  - Stimulus: LW with rt = 8 in EX; ID holds add with rs = 8.
  - Response: lu_stall = 1, next cycle ex_valid = 0 and ex_ctrl = 0, bubble_cnt = 1.
- Load-use, ex_rt = 0: same pair with ex_rt = 0 -> lu_stall = 0.
- Pending flush: flush pulsed during a 3-cycle hold -> contents frozen during the hold; the first edge after hold drops loads a bubble; pend_flush is 0 afterwards.
- X sanitising: SW with RegDst = x, MemtoReg = x -> ex_ctrl RegDst = 0, MemtoReg = 0, MemWrite = 1, ALUSrc = 1.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the 5-stage MIPS pipeline.
//   - Control-bundle bit positions (MSB first: RegDst .. ALUOp[1:0]) and width
//   - Primary opcode constants
//   - ALUOp encodings
package mips_pkg;

  localparam int CTRL_W        = 12;
  localparam int CTRL_REGDST   = 11;
  localparam int CTRL_ALUSRC   = 10;
  localparam int CTRL_MEMTOREG = 9;
  localparam int CTRL_REGWRITE = 8;
  localparam int CTRL_MEMREAD  = 7;
  localparam int CTRL_MEMWRITE = 6;
  localparam int CTRL_ORI      = 5;
  localparam int CTRL_BEQ      = 4;
  localparam int CTRL_BNE      = 3;
  localparam int CTRL_JUMP     = 2;
  localparam int CTRL_ALUOP    = 0;  // LSB of the 2-bit ALUOp field
  localparam int ALUOP_W       = 2;

  localparam logic [5:0] R_FORMAT = 6'd0;
  localparam logic [5:0] J        = 6'd2;
  localparam logic [5:0] BEQ      = 6'd4;
  localparam logic [5:0] BNE      = 6'd5;
  localparam logic [5:0] ORI      = 6'd13;
  localparam logic [5:0] LW       = 6'd35;
  localparam logic [5:0] SW       = 6'd43;

  typedef enum logic [ALUOP_W-1:0] {
    ALUOP_ADD   = 2'b00,  // address calculation (LW/SW)
    ALUOP_SUB   = 2'b01,  // branch compare
    ALUOP_FUNCT = 2'b10   // R-format, decode funct field
  } aluop_e;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: combinational load-use hazard detector.
//   Asserts lu_stall when the instruction in EX is a valid load whose
//   destination (rt, nonzero) is a source of the valid instruction in ID.
// Ports:
//   ex_valid, ex_mem_read, ex_rt : load currently in EX
//   id_valid, id_rs, id_rt       : instruction currently in ID
//   lu_stall                     : stall request (zero latency)
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              lu_stall
);

  // $zero is never a real dependency, so a load targeting r0 never stalls.
  assign lu_stall = ex_valid & ex_mem_read & id_valid & (ex_rt != '0) &
                    ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, bubble
// insertion, downstream hold and flush (remembered across a hold).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   id_*                  : decoded instruction from ID
//   hold                  : freeze the register (downstream stall)
//   flush                 : kill the instruction entering EX
//   lu_stall              : combinational load-use stall to PC and IF/ID
//   ex_*                  : registered fields presented to EX
//   bubble_cnt            : saturating count of inserted bubbles
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [11:0]       id_ctrl,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [5:0]        id_funct,
  input  logic              hold,
  input  logic              flush,
  output logic              lu_stall,
  output logic              ex_valid,
  output logic [11:0]       ex_ctrl,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [5:0]        ex_funct,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              valid_q,    valid_d;
  logic [CTRL_W-1:0] ctrl_q,     ctrl_d;
  logic [DATA_W-1:0] rs_data_q,  rs_data_d;
  logic [DATA_W-1:0] rt_data_q,  rt_data_d;
  logic [DATA_W-1:0] imm_q,      imm_d;
  logic [DATA_W-1:0] pc4_q,      pc4_d;
  logic [REG_AW-1:0] rs_q,       rs_d;
  logic [REG_AW-1:0] rt_q,       rt_d;
  logic [REG_AW-1:0] rd_q,       rd_d;
  logic [5:0]        funct_q,    funct_d;
  logic              pend_flush_q, pend_flush_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;

  logic [CTRL_W-1:0] ctrl_clean;
  logic              bubble;

  // The decoder leaves don't-care control bits as X; only a definite 1 is
  // passed on, and nothing at all is passed on for an invalid slot.
  genvar gi;
  generate
    for (gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_clean
      assign ctrl_clean[gi] = id_valid & (id_ctrl[gi] === 1'b1);
    end
  endgenerate

  load_use_detect #(
    .REG_AW (REG_AW)
  ) u_lu (
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q[CTRL_MEMREAD]),
    .ex_rt       (rt_q),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .lu_stall    (lu_stall)
  );

  // A flush (live or remembered) and a load-use stall each produce exactly
  // one bubble; when both coincide it is still a single bubble.
  assign bubble = flush | pend_flush_q | lu_stall;

  always_comb begin
    valid_d      = valid_q;
    ctrl_d       = ctrl_q;
    rs_data_d    = rs_data_q;
    rt_data_d    = rt_data_q;
    imm_d        = imm_q;
    pc4_d        = pc4_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rd_d         = rd_q;
    funct_d      = funct_q;
    pend_flush_d = pend_flush_q;
    cnt_d        = cnt_q;

    if (hold) begin
      // Frozen; a flush arriving now must not be lost.
      pend_flush_d = pend_flush_q | flush;
    end else begin
      // Data fields load even for a bubble so the waveform shows what was killed.
      rs_data_d    = id_rs_data;
      rt_data_d    = id_rt_data;
      imm_d        = id_imm;
      pc4_d        = id_pc4;
      rs_d         = id_rs;
      rt_d         = id_rt;
      rd_d         = id_rd;
      funct_d      = id_funct;
      pend_flush_d = 1'b0;
      if (bubble) begin
        valid_d = 1'b0;
        ctrl_d  = '0;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        valid_d = id_valid;
        ctrl_d  = ctrl_clean;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      ctrl_q       <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      pc4_q        <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      funct_q      <= '0;
      pend_flush_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      valid_q      <= valid_d;
      ctrl_q       <= ctrl_d;
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_q        <= imm_d;
      pc4_q        <= pc4_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      funct_q      <= funct_d;
      pend_flush_q <= pend_flush_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ex_valid   = valid_q;
  assign ex_ctrl    = ctrl_q;
  assign ex_rs_data = rs_data_q;
  assign ex_rt_data = rt_data_q;
  assign ex_imm     = imm_q;
  assign ex_pc4     = pc4_q;
  assign ex_rs      = rs_q;
  assign ex_rt      = rt_q;
  assign ex_rd      = rd_q;
  assign ex_funct   = funct_q;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage. The stimulus process
// drives one instruction slot per cycle and queues the hand-computed
// response; the monitor samples lu_stall just before each rising edge and
// the registered outputs just after it, then compares against the queue.
// bubble_cnt is built 3 bits wide so saturation is reachable quickly.
module tb_id_ex_stage;

  localparam logic [11:0] C_R   = 12'h902;  // RegDst, RegWrite, ALUOp=10
  localparam logic [11:0] C_LW  = 12'h780;  // ALUSrc, MemtoReg, RegWrite, MemRead
  localparam logic [11:0] C_ORI = 12'h520;  // ALUSrc, RegWrite, Ori
  localparam logic [11:0] C_SWX = 12'bx1x0_0100_0000;  // SW, RegDst/MemtoReg don't-care
  localparam logic [11:0] C_SW  = 12'h440;  // SW after sanitising

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [11:0] id_ctrl;
  logic [31:0] id_rs_data, id_rt_data, id_imm, id_pc4;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [5:0]  id_funct;
  logic        hold, flush;
  logic        lu_stall, ex_valid;
  logic [11:0] ex_ctrl;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [5:0]  ex_funct;
  logic [2:0]  bubble_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_ctrl    (id_ctrl),
    .id_rs_data (id_rs_data),
    .id_rt_data (id_rt_data),
    .id_imm     (id_imm),
    .id_pc4     (id_pc4),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rd      (id_rd),
    .id_funct   (id_funct),
    .hold       (hold),
    .flush      (flush),
    .lu_stall   (lu_stall),
    .ex_valid   (ex_valid),
    .ex_ctrl    (ex_ctrl),
    .ex_rs_data (ex_rs_data),
    .ex_rt_data (ex_rt_data),
    .ex_imm     (ex_imm),
    .ex_pc4     (ex_pc4),
    .ex_rs      (ex_rs),
    .ex_rt      (ex_rt),
    .ex_rd      (ex_rd),
    .ex_funct   (ex_funct),
    .bubble_cnt (bubble_cnt)
  );

  typedef struct {
    string       name;
    logic        lu;
    logic        valid;
    logic [11:0] ctrl;
    logic [31:0] rsd;
    logic [4:0]  rt;
    logic [2:0]  cnt;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic cmp(input string nm, input string fld,
                     input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, exp);
    end
  endtask

  task automatic push_exp(input string nm, input logic e_lu, input logic e_valid,
                          input logic [11:0] e_ctrl, input logic [31:0] e_rsd,
                          input logic [4:0] e_rt, input logic [2:0] e_cnt);
    exp_t e;
    e.name = nm; e.lu = e_lu; e.valid = e_valid; e.ctrl = e_ctrl;
    e.rsd = e_rsd; e.rt = e_rt; e.cnt = e_cnt;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [11:0] c, input logic [31:0] rsd,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic h, input logic f);
    id_valid   = v;
    id_ctrl    = c;
    id_rs_data = rsd;
    id_rt_data = rsd ^ 32'h0000_ffff;
    id_imm     = {27'd0, rd};
    id_pc4     = rsd << 2;
    id_rs      = rs;
    id_rt      = rt;
    id_rd      = rd;
    id_funct   = 6'h20;
    hold       = h;
    flush      = f;
  endtask

  // One cycle: inputs applied at the falling edge, response expected after
  // the following rising edge.
  task automatic apply(input string nm, input logic v, input logic [11:0] c,
                       input logic [31:0] rsd, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic h, input logic f,
                       input logic e_lu, input logic e_valid, input logic [11:0] e_ctrl,
                       input logic [31:0] e_rsd, input logic [4:0] e_rt,
                       input logic [2:0] e_cnt);
    @(negedge clk);
    drive(v, c, rsd, rs, rt, rd, h, f);
    push_exp(nm, e_lu, e_valid, e_ctrl, e_rsd, e_rt, e_cnt);
  endtask

  // Monitor
  initial begin
    logic lu_s;
    exp_t e;
    forever begin
      @(negedge clk);
      #4 lu_s = lu_stall;
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cmp(e.name, "lu_stall",   {31'd0, lu_s},       {31'd0, e.lu});
        cmp(e.name, "ex_valid",   {31'd0, ex_valid},   {31'd0, e.valid});
        cmp(e.name, "ex_ctrl",    {20'd0, ex_ctrl},    {20'd0, e.ctrl});
        cmp(e.name, "ex_rs_data", ex_rs_data,          e.rsd);
        cmp(e.name, "ex_rt",      {27'd0, ex_rt},      {27'd0, e.rt});
        cmp(e.name, "bubble_cnt", {29'd0, bubble_cnt}, {29'd0, e.cnt});
        $display("%0t %s: lu=%0b valid=%0b ctrl=%03h rs_data=%08h rt=%0d cnt=%0d",
                 $time, e.name, lu_s, ex_valid, ex_ctrl, ex_rs_data, ex_rt, bubble_cnt);
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d expected 0", sb_q.size());
    $fatal(1);
  end

  // Stimulus
  initial begin
    rst_n = 1'b1;
    drive(1'b0, 12'h000, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #2;
    cmp("reset", "ex_valid",   {31'd0, ex_valid},   32'd0);
    cmp("reset", "ex_ctrl",    {20'd0, ex_ctrl},    32'd0);
    cmp("reset", "bubble_cnt", {29'd0, bubble_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //     name                  v     ctrl   rsd         rs    rt     rd    h     f     lu    val   e_ctrl e_rsd     e_rt   cnt
    apply("normal_load",        1'b1, C_R,   32'h11,  5'd1, 5'd2,  5'd3, 1'b0, 1'b0, 1'b0, 1'b1, C_R,   32'h11,  5'd2,  3'd0);
    apply("lw_rt8",             1'b1, C_LW,  32'h20,  5'd4, 5'd8,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_LW,  32'h20,  5'd8,  3'd0);
    apply("lu_dep_rs",          1'b1, C_R,   32'h33,  5'd8, 5'd9,  5'd10,1'b0, 1'b0, 1'b1, 1'b0, 12'h0, 32'h33,  5'd9,  3'd1);
    apply("lu_reissue",         1'b1, C_R,   32'h33,  5'd8, 5'd9,  5'd10,1'b0, 1'b0, 1'b0, 1'b1, C_R,   32'h33,  5'd9,  3'd1);
    apply("lw_rt0",             1'b1, C_LW,  32'h44,  5'd4, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_LW,  32'h44,  5'd0,  3'd1);
    apply("lu_rt_zero",         1'b1, C_R,   32'h55,  5'd0, 5'd5,  5'd6, 1'b0, 1'b0, 1'b0, 1'b1, C_R,   32'h55,  5'd5,  3'd1);
    apply("lw_rt7",             1'b1, C_LW,  32'h66,  5'd1, 5'd7,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_LW,  32'h66,  5'd7,  3'd1);
    apply("hold_with_lu",       1'b1, C_R,   32'h77,  5'd2, 5'd7,  5'd3, 1'b1, 1'b0, 1'b1, 1'b1, C_LW,  32'h66,  5'd7,  3'd1);
    apply("flush_with_lu",      1'b1, C_R,   32'h77,  5'd2, 5'd7,  5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 12'h0, 32'h77,  5'd7,  3'd2);
    apply("after_flush_lu",     1'b1, C_R,   32'h77,  5'd2, 5'd7,  5'd3, 1'b0, 1'b0, 1'b0, 1'b1, C_R,   32'h77,  5'd7,  3'd2);
    apply("hold1_flush",        1'b1, C_ORI, 32'h88,  5'd3, 5'd4,  5'd0, 1'b1, 1'b1, 1'b0, 1'b1, C_R,   32'h77,  5'd7,  3'd2);
    apply("hold2",              1'b1, C_ORI, 32'h88,  5'd3, 5'd4,  5'd0, 1'b1, 1'b0, 1'b0, 1'b1, C_R,   32'h77,  5'd7,  3'd2);
    apply("hold3",              1'b1, C_ORI, 32'h88,  5'd3, 5'd4,  5'd0, 1'b1, 1'b0, 1'b0, 1'b1, C_R,   32'h77,  5'd7,  3'd2);
    apply("pend_flush_bubble",  1'b1, C_ORI, 32'h88,  5'd3, 5'd4,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h88,  5'd4,  3'd3);
    apply("pend_flush_cleared", 1'b1, C_ORI, 32'h88,  5'd3, 5'd4,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_ORI, 32'h88,  5'd4,  3'd3);
    apply("invalid_ctrl_zero",  1'b0, C_R,   32'h99,  5'd1, 5'd2,  5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h99,  5'd2,  3'd3);
    apply("x_sanitise_sw",      1'b1, C_SWX, 32'hAA,  5'd5, 5'd6,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_SW,  32'hAA,  5'd6,  3'd3);

    // Consecutive flushes drive the 3-bit counter into saturation at 7.
    for (int i = 0; i < 5; i++) begin
      apply("flush_saturate", 1'b1, C_R, 32'h100 + i, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1,
            1'b0, 1'b0, 12'h0, 32'h100 + i, 5'd2, (i < 3) ? 3'(4 + i) : 3'd7);
    end

    apply("load_before_reset",  1'b1, C_R,   32'h120, 5'd1, 5'd2,  5'd3, 1'b0, 1'b0, 1'b0, 1'b1, C_R,   32'h120, 5'd2,  3'd7);
    apply("hold_flush_pending", 1'b1, C_R,   32'h130, 5'd1, 5'd2,  5'd3, 1'b1, 1'b1, 1'b0, 1'b1, C_R,   32'h120, 5'd2,  3'd7);

    // Asynchronous reset mid-hold with ex_valid=1 and a pending flush; the
    // first edge after release must load normally (pending flush discarded).
    @(negedge clk);
    drive(1'b1, C_R, 32'hBB, 5'd1, 5'd3, 5'd4, 1'b0, 1'b0);
    push_exp("load_after_reset", 1'b0, 1'b1, C_R, 32'hBB, 5'd3, 3'd0);
    #2 rst_n = 1'b0;
    #1;
    cmp("async_reset", "ex_valid",   {31'd0, ex_valid},   32'd0);
    cmp("async_reset", "ex_ctrl",    {20'd0, ex_ctrl},    32'd0);
    cmp("async_reset", "ex_rs_data", ex_rs_data,          32'd0);
    cmp("async_reset", "bubble_cnt", {29'd0, bubble_cnt}, 32'd0);
    #1 rst_n = 1'b1;

    apply("lw_rt10",            1'b1, C_LW,  32'hCC,  5'd5, 5'd10, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_LW,  32'hCC,  5'd10, 3'd0);
    apply("lu_dep_rt",          1'b1, C_R,   32'hDD,  5'd1, 5'd10, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0, 32'hDD,  5'd10, 3'd1);

    @(negedge clk);
    drive(1'b0, 12'h000, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    cmp("drain", "pending", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
